// File: rtl/stream_ctrl_pkg.sv
// Shared types and default sizing for the SDRAM stream test path.
package stream_ctrl_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned DEF_BURST_LEN  = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 16;
    localparam int unsigned DEF_ADDR_W     = 22;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        REQ,
        BURST,
        FLUSH
    } state_t;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is accepted only
// when a pop happens in the same cycle. An empty FIFO presents 0 at its head.
module stream_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking; clear wins over any push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(push_ok) - LVL_W'(pop_ok);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/stream_burst_scheduler.sv
// Buffers the counter stream and packs it into linear fixed-length SDRAM write
// bursts, flagging dropped words. Define STREAM_STATS_EN to add the
// words_written / drop_count statistics outputs.
module stream_burst_scheduler
    import stream_ctrl_pkg::*;
#(
    parameter int unsigned BURST_LEN  = DEF_BURST_LEN,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic              gen_enable,
    input  logic [WORD_W-1:0] gen_data,
    input  logic              gen_rdy,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_ack,
    output logic [WORD_W-1:0] wr_data,
    input  logic              wr_next,
    output logic              busy,
    output logic              done,
    output logic              overflow
`ifdef STREAM_STATS_EN
    ,
    output logic [31:0]       words_written,
    output logic [15:0]       drop_count
`endif
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNT_W = $clog2(BURST_LEN);

    state_t            state;
    state_t            state_nxt;
    logic              stop_pending;
    logic              stop_pending_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [CNT_W-1:0]  pop_cnt;
    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_clear_c;
    logic              accept_c;
    logic              push_c;
    logic              pop_c;
    logic              drop_c;
    logic              last_pop_c;
    logic              stop_req_c;

    assign accept_c   = (state == RUN) || (state == REQ) || (state == BURST);
    assign push_c     = gen_rdy && accept_c;
    assign pop_c      = (state == BURST) && wr_next && !fifo_empty;
    assign drop_c     = push_c && fifo_full && !pop_c;
    assign last_pop_c = pop_c && (pop_cnt == CNT_W'(BURST_LEN - 1));
    assign stop_req_c = stop || stop_pending;

    stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (fifo_clear_c),
        .push  (push_c),
        .pop   (pop_c),
        .din   (gen_data),
        .dout  (wr_data),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state, address advance, stop latch and FIFO clear decode.
    always_comb begin
        state_nxt        = state;
        stop_pending_nxt = stop_pending;
        addr_nxt         = wr_addr;
        fifo_clear_c     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = RUN;
                    addr_nxt     = '0;
                    fifo_clear_c = 1'b1;
                end
            end
            RUN: begin
                if (stop_req_c)                          state_nxt = FLUSH;
                else if (fifo_level >= LVL_W'(BURST_LEN)) state_nxt = REQ;
            end
            REQ: begin
                if (wr_ack) state_nxt = BURST;
            end
            BURST: begin
                if (last_pop_c) begin
                    addr_nxt  = wr_addr + ADDR_W'(BURST_LEN);
                    state_nxt = stop_req_c ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                fifo_clear_c = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE && stop) stop_pending_nxt = 1'b1;
        if (state_nxt == IDLE)     stop_pending_nxt = 1'b0;
    end

    // State, stop latch, burst address and pop counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            stop_pending <= 1'b0;
            wr_addr      <= '0;
            pop_cnt      <= '0;
        end else begin
            state        <= state_nxt;
            stop_pending <= stop_pending_nxt;
            wr_addr      <= addr_nxt;
            if (pop_c) pop_cnt <= pop_cnt + CNT_W'(1);
        end
    end

    // Registered control outputs decoded from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_enable <= 1'b0;
            wr_req     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            gen_enable <= ((state_nxt == RUN) || (state_nxt == REQ) || (state_nxt == BURST))
                          && !stop_pending_nxt;
            wr_req     <= (state_nxt == REQ);
            busy       <= (state_nxt != IDLE);
            done       <= (state == FLUSH);
        end
    end

    // Sticky loss flag, cleared when a new run starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          overflow <= 1'b0;
        else if (state == IDLE && start)  overflow <= 1'b0;
        else if (drop_c)                  overflow <= 1'b1;
    end

`ifdef STREAM_STATS_EN
    // Run statistics: words handed to the controller and saturating drop count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_written <= '0;
            drop_count    <= '0;
        end else if (state == IDLE && start) begin
            words_written <= '0;
            drop_count    <= '0;
        end else begin
            if (pop_c) words_written <= words_written + 32'd1;
            if (drop_c && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_burst_scheduler.sv
// Self-checking bench for stream_burst_scheduler (ADDR_W=5 to exercise wrap).
module tb_stream_burst_scheduler;

    localparam int BL    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          gen_enable;
    logic [31:0]   gen_data;
    logic          gen_rdy;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic          wr_ack;
    logic [31:0]   wr_data;
    logic          wr_next;
    logic          busy;
    logic          done;
    logic          overflow;
`ifdef STREAM_STATS_EN
    logic [31:0]   words_written;
    logic [15:0]   drop_count;
`endif

    stream_burst_scheduler #(
        .BURST_LEN  (BL),
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .gen_enable (gen_enable),
        .gen_data   (gen_data),
        .gen_rdy    (gen_rdy),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_ack     (wr_ack),
        .wr_data    (wr_data),
        .wr_next    (wr_next),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
`ifdef STREAM_STATS_EN
        ,
        .words_written (words_written),
        .drop_count    (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] q[$];
    logic [31:0] next_word = 32'd0;
    int          m_addr    = 0;
    bit          m_ovf     = 1'b0;
    int          m_drops   = 0;
    int          m_pops    = 0;
    int          done_seen = 0;

    function automatic bit rnd(input int pct);
        return ($urandom_range(99) < 32'(pct));
    endfunction

    // One clock: drive inputs at the negedge, advance the model, sample at the next negedge.
    task automatic drive_cycle(input bit start_v, input bit stop_v, input bit rdy_req,
                               input bit ack_v, input bit next_v, input bit no_drop);
        bit rdy_v;
        rdy_v = rdy_req && (gen_enable === 1'b1);
        if (no_drop && q.size() >= DEPTH && !next_v) rdy_v = 1'b0;
        if (next_v) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL wr_next_underflow got=%08h exp=<model empty>", wr_data);
            end else begin
                if (wr_data !== q[0]) begin
                    failures++;
                    $display("FAIL wr_data got=%08h exp=%08h", wr_data, q[0]);
                end
                void'(q.pop_front());
            end
            m_pops++;
        end
        if (rdy_v) begin
            if (q.size() < DEPTH) q.push_back(next_word);
            else begin
                m_ovf = 1'b1;
                m_drops++;
            end
        end
        start    = start_v;
        stop     = stop_v;
        gen_rdy  = rdy_v;
        gen_data = next_word;
        wr_ack   = ack_v;
        wr_next  = next_v;
        if (rdy_v) next_word = next_word + 32'd1;
        @(negedge clk);
        if (done === 1'b1) done_seen++;
    endtask

    task automatic do_start();
        q.delete();
        m_addr  = 0;
        m_ovf   = 1'b0;
        m_drops = 0;
        m_pops  = 0;
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (gen_enable !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_response got=gen_enable:%b busy:%b exp=1 1", gen_enable, busy);
        end
    endtask

    task automatic do_burst(input int ack_delay, input int pct, input int stop_at, input bit no_drop);
        int t;
        int t_level;
        t = 0;
        t_level = -1;
        while (wr_req !== 1'b1 && t < 300) begin
            if (t_level < 0 && q.size() >= BL) t_level = t;
            drive_cycle(1'b0, 1'b0, rnd(pct), ($urandom_range(3) == 0), 1'b0, no_drop);
            t++;
        end
        checks++;
        if (wr_req !== 1'b1 || t !== t_level + 1) begin
            failures++;
            $display("FAIL wr_req_latency got=wr_req:%b after %0d cycles exp=1 after %0d", wr_req, t, t_level + 1);
            return;
        end
        checks++;
        if (wr_addr !== AW'(m_addr)) begin
            failures++;
            $display("FAIL wr_addr got=%0d exp=%0d", wr_addr, m_addr);
        end
        repeat (ack_delay) drive_cycle(1'b0, 1'b0, rnd(pct), 1'b0, 1'b0, no_drop);
        checks++;
        if (wr_req !== 1'b1 || wr_addr !== AW'(m_addr)) begin
            failures++;
            $display("FAIL wr_req_hold got=%b/%0d exp=1/%0d", wr_req, wr_addr, m_addr);
        end
        drive_cycle(1'b0, 1'b0, rnd(pct), 1'b1, 1'b0, no_drop);
        checks++;
        if (wr_req !== 1'b0) begin
            failures++;
            $display("FAIL wr_req_fall got=%b exp=0", wr_req);
        end
        for (int i = 0; i < BL; i++) begin
            drive_cycle(1'b0, (i == stop_at), rnd(pct), 1'b0, 1'b1, no_drop);
            if (i == stop_at) begin
                checks++;
                if (gen_enable !== 1'b0) begin
                    failures++;
                    $display("FAIL gen_enable_after_stop got=%b exp=0", gen_enable);
                end
            end
        end
        m_addr = (m_addr + BL) % (1 << AW);
        checks++;
        if (overflow !== m_ovf) begin
            failures++;
            $display("FAIL overflow got=%b exp=%b", overflow, m_ovf);
        end
    endtask

    // Called right after the final pop of a stopped run.
    task automatic end_run();
        checks++;
        if (busy !== 1'b1 || gen_enable !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL flush_state got=busy:%b gen_enable:%b done:%b exp=1 0 0", busy, gen_enable, done);
        end
        done_seen = 0;
        repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (done_seen !== 1) begin
            failures++;
            $display("FAIL done_pulse got=%0d exp=1", done_seen);
        end
        checks++;
        if (busy !== 1'b0 || wr_data !== 32'd0) begin
            failures++;
            $display("FAIL idle_after_flush got=busy:%b wr_data:%08h exp=0 00000000", busy, wr_data);
        end
`ifdef STREAM_STATS_EN
        checks++;
        if (words_written !== 32'(m_pops) || drop_count !== 16'((m_drops > 65535) ? 65535 : m_drops)) begin
            failures++;
            $display("FAIL stats got=%0d/%0d exp=%0d/%0d", words_written, drop_count, m_pops, m_drops);
        end
`endif
        q.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({gen_enable, wr_req, busy, done, overflow} !== 5'b0 || wr_addr !== '0 || wr_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_values got=%b%b%b%b%b addr=%0d data=%08h exp=00000 0 0",
                     gen_enable, wr_req, busy, done, overflow, wr_addr, wr_data);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gen_enable !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold got=busy:%b gen_enable:%b exp=0 0", busy, gen_enable);
        end
    endtask

    task automatic test_stream();
        next_word = 32'hFAFBFCFD;
        do_start();
        for (int b = 0; b < 4; b++) do_burst(0, 100, (b == 3) ? BL - 1 : -1, 1'b0);
        end_run();
    endtask

    task automatic test_overflow();
        do_start();
        do_burst(40, 100, -1, 1'b0);
        checks++;
        if (overflow !== 1'b1 || m_drops == 0) begin
            failures++;
            $display("FAIL overflow_set got=%b exp=1 (model drops %0d)", overflow, m_drops);
        end
        do_burst(0, 100, -1, 1'b0);
        do_burst(0, 100, BL - 1, 1'b0);
        end_run();
    endtask

    task automatic test_stop_mid_burst();
        do_start();
        do_burst(0, 100, 3, 1'b0);
        end_run();
    endtask

    task automatic test_addr_wrap();
        do_start();
        for (int b = 0; b < 5; b++) do_burst($urandom_range(3), 70, (b == 4) ? BL - 1 : -1, 1'b0);
        end_run();
    endtask

    task automatic test_full_simultaneous();
        do_start();
        do_burst(12, 100, BL - 1, 1'b1);
        end_run();
        wr_next = 1'b1;
        wr_ack  = 1'b1;
        repeat (2) @(negedge clk);
        wr_next = 1'b0;
        wr_ack  = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_data !== 32'd0 || busy !== 1'b0 || wr_req !== 1'b0) begin
            failures++;
            $display("FAIL idle_wr_next got=data:%08h busy:%b wr_req:%b exp=0 0 0", wr_data, busy, wr_req);
        end
    endtask

    task automatic test_reset_in_req();
        int t;
        do_start();
        do_burst(40, 100, -1, 1'b0);
        t = 0;
        while (wr_req !== 1'b1 && t < 100) begin
            drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            t++;
        end
        checks++;
        if (wr_req !== 1'b1 || overflow !== m_ovf) begin
            failures++;
            $display("FAIL pre_reset_req got=wr_req:%b ovf:%b exp=1 %b", wr_req, overflow, m_ovf);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({gen_enable, wr_req, busy, done, overflow} !== 5'b0 || wr_addr !== '0 || wr_data !== 32'd0) begin
            failures++;
            $display("FAIL async_reset got=%b%b%b%b%b addr=%0d data=%08h exp=00000 0 0",
                     gen_enable, wr_req, busy, done, overflow, wr_addr, wr_data);
        end
        start = 1'b0; stop = 1'b0; gen_rdy = 1'b0; wr_ack = 1'b0; wr_next = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start();
        do_burst(0, 100, BL - 1, 1'b0);
        end_run();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; gen_rdy = 1'b0;
        gen_data = 32'd0; wr_ack = 1'b0; wr_next = 1'b0;
        test_reset();
        test_stream();
        test_overflow();
        test_stop_mid_burst();
        test_addr_wrap();
        test_full_simultaneous();
        test_reset_in_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
